// File: rtl/c880_seq_pkg.sv
// Shared types and constants for the c880 vector sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, c880 port widths, 26-bit MISR polynomial,
//           and a helper that sizes the settle counter.
package c880_seq_pkg;

  localparam int C880_VEC_W = 60;
  localparam int C880_OUT_W = 26;

  // x^26 + x^6 + x^2 + x + 1 (the x^26 term is implicit in the shift-out)
  localparam logic [25:0] MISR_POLY_26 = 26'h0000047;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } seq_state_e;

  // Counter must hold the value SETTLE; a zero-length settle still needs one bit.
  function automatic int settle_cnt_w(input int settle);
    return (settle > 0) ? $clog2(settle + 1) : 1;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: compacts a stream of words into one word.
// Latency: signature reflects din one cycle after the en edge.
// Backpressure: none; caller gates with en. clr has priority over en.
// Ports: clk, rst (async high), clr (sync zero), en (fold din), din, sig.
module misr_reg #(
  parameter int            W    = 26,
  parameter logic [W-1:0]  POLY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c880_vec_sequencer.sv
// Steps through VEC_LEN ROM vectors, applies each to the c880 netlist, waits
// SETTLE cycles, captures the response to a valid/ready stream and a MISR.
// Latency: SETTLE+3 cycles per vector with cap_ready high; done one cycle.
// Backpressure: CAPTURE holds cap_data/cap_idx indefinitely until cap_ready.
// Ports: start/busy/done run control; vec_addr/vec_data sync ROM;
//        dut_in/dut_out netlist; cap_* logger stream; signature MISR.
module c880_vec_sequencer
  import c880_seq_pkg::*;
#(
  parameter int                 VEC_W     = C880_VEC_W,
  parameter int                 OUT_W     = C880_OUT_W,
  parameter int                 VEC_LEN   = 64,
  parameter int                 ADDR_W    = 6,
  parameter int                 SETTLE    = 2,
  parameter logic [OUT_W-1:0]   MISR_POLY = MISR_POLY_26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [VEC_W-1:0]  vec_data,
  output logic [VEC_W-1:0]  dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [OUT_W-1:0]  cap_data,
  output logic [ADDR_W-1:0] cap_idx,
  output logic [OUT_W-1:0]  signature
);

  localparam int                CNT_W      = settle_cnt_w(SETTLE);
  localparam logic [CNT_W-1:0]  SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(VEC_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  seq_state_e        state_q;
  logic              busy_q;
  logic              done_q;
  logic              cap_valid_q;
  logic [ADDR_W-1:0] vec_addr_q;
  logic [VEC_W-1:0]  dut_in_q;
  logic [OUT_W-1:0]  cap_data_q;
  logic [ADDR_W-1:0] cap_idx_q;
  logic [CNT_W-1:0]  settle_cnt_q;

  logic misr_clr;
  logic misr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cap_valid_q  <= 1'b0;
      vec_addr_q   <= '0;
      dut_in_q     <= '0;
      cap_data_q   <= '0;
      cap_idx_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_FETCH;
            vec_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        // ROM registers vec_addr this cycle; data is usable in LOAD.
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          dut_in_q     <= vec_data;
          settle_cnt_q <= SETTLE_CNT;
          if (SETTLE > 0) begin
            state_q <= ST_SETTLE;
          end else begin
            // Zero settle: response is sampled on the same edge dut_in updates.
            state_q     <= ST_CAPTURE;
            cap_data_q  <= dut_out;
            cap_idx_q   <= vec_addr_q;
            cap_valid_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          settle_cnt_q <= settle_cnt_q - CNT_ONE;
          if (settle_cnt_q == CNT_ONE) begin
            state_q     <= ST_CAPTURE;
            cap_data_q  <= dut_out;
            cap_idx_q   <= vec_addr_q;
            cap_valid_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (cap_ready) begin
            cap_valid_q <= 1'b0;
            if (vec_addr_q == LAST_ADDR) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_addr_q <= vec_addr_q + ADDR_ONE;
              state_q    <= ST_FETCH;
            end
          end
        end
        // start is deliberately not looked at here.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign misr_clr = (state_q == ST_IDLE) && start;
  assign misr_en  = cap_valid_q && cap_ready;

  misr_reg #(
    .W    (OUT_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din (cap_data_q),
    .sig (signature)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_addr  = vec_addr_q;
  assign dut_in    = dut_in_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign cap_idx   = cap_idx_q;

endmodule
